// File: rtl/car_collision.sv
// Frog/car collision check, one lane per cycle after each frame tick.
// Optional COLLISION_LANE_ID_EN adds hit_lane (index of the last hit).
module car_collision #(
  parameter int CAR_W       = 32,
  parameter int FROG_W      = 32,
  parameter int LANE_Y_BASE = 64,
  parameter int LANE_PITCH  = 32,
  parameter int LIVES       = 3,
  parameter int COOLDOWN    = 60
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       frame_tick,
  input  logic [9:0] frog_x,
  input  logic [9:0] frog_y,
  input  logic [9:0] car_x1,
  input  logic [9:0] car_x2,
  input  logic [9:0] car_x3,
  input  logic [9:0] car_x4,
  input  logic [9:0] car_x5,
  input  logic [9:0] car_x6,
  output logic       hit,
  output logic [1:0] lives,
  output logic       game_over,
  output logic       busy
`ifdef COLLISION_LANE_ID_EN
  ,
  output logic [2:0] hit_lane
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    HIT,
    COOLDOWN_ST,
    OVER
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [2:0]  idx;
  logic [9:0]  fx_q;
  logic [9:0]  fy_q;
  logic [9:0]  car_q [6];
  logic [1:0]  lives_q;
  logic [7:0]  cnt;

  logic [9:0]  car_sel;
  logic [9:0]  d_fc;
  logic [9:0]  d_cf;
  logic [11:0] lane_lo;
  logic [11:0] lane_hi;
  logic [11:0] fy_w;
  logic        vert;
  logic        horiz;
  logic        match;

  // Select the snapshotted car for the lane under test
  always_comb begin
    car_sel = car_q[0];
    case (idx)
      3'd0:    car_sel = car_q[0];
      3'd1:    car_sel = car_q[1];
      3'd2:    car_sel = car_q[2];
      3'd3:    car_sel = car_q[3];
      3'd4:    car_sel = car_q[4];
      3'd5:    car_sel = car_q[5];
      default: car_sel = car_q[0];
    endcase
  end

  // Overlap test for the current lane; x distances wrap mod 1024
  always_comb begin
    lane_lo = 12'(LANE_Y_BASE) + 12'(idx) * 12'(LANE_PITCH);
    lane_hi = lane_lo + 12'(LANE_PITCH - 1);
    fy_w    = {2'b00, fy_q};
    vert    = (fy_w >= lane_lo) && (fy_w <= lane_hi);
    d_fc    = fx_q - car_sel;
    d_cf    = car_sel - fx_q;
    horiz   = ({1'b0, d_fc} < 11'(CAR_W)) ||
              ({1'b0, d_cf} < 11'(FROG_W));
    match   = vert && horiz;
  end

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:
        if (frame_tick) state_n = SCAN;
      SCAN:
        if (match)            state_n = HIT;
        else if (idx == 3'd5) state_n = IDLE;
      HIT:
        if (lives_q <= 2'd1) state_n = OVER;
        else                 state_n = COOLDOWN_ST;
      COOLDOWN_ST:
        if (frame_tick && cnt <= 8'd1) state_n = IDLE;
      OVER:
        state_n = OVER;
      default:
        state_n = IDLE;
    endcase
  end

  // Snapshot, lane index, lives and cooldown bookkeeping
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idx     <= 3'd0;
      fx_q    <= 10'd0;
      fy_q    <= 10'd0;
      for (int i = 0; i < 6; i++) car_q[i] <= 10'd0;
      lives_q <= 2'(LIVES);
      cnt     <= 8'd0;
    end else begin
      if (state == IDLE && frame_tick) begin
        idx      <= 3'd0;
        fx_q     <= frog_x;
        fy_q     <= frog_y;
        car_q[0] <= car_x1;
        car_q[1] <= car_x2;
        car_q[2] <= car_x3;
        car_q[3] <= car_x4;
        car_q[4] <= car_x5;
        car_q[5] <= car_x6;
      end else if (state == SCAN) begin
        idx <= idx + 3'd1;
      end
      if (state == HIT) begin
        if (lives_q != 2'd0) lives_q <= lives_q - 2'd1;
        if (lives_q > 2'd1)  cnt <= 8'(COOLDOWN);
      end else if (state == COOLDOWN_ST && frame_tick && cnt != 8'd0) begin
        cnt <= cnt - 8'd1;
      end
    end
  end

`ifdef COLLISION_LANE_ID_EN
  // Remember which lane produced the last hit; 7 means none yet
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                      hit_lane <= 3'd7;
    else if (state == SCAN && match) hit_lane <= idx;
  end
`endif

  // OVER reads as idle-not-busy so downstream stages do not stall on it
  assign hit       = (state == HIT);
  assign lives     = lives_q;
  assign game_over = (state == OVER);
  assign busy      = (state != IDLE) && (state != OVER);

endmodule

// File: tb/tb_car_collision.sv
// Randomised bench for car_collision against a frame-level model.
// Build with COLLISION_LANE_ID_EN to also check hit_lane.
module tb_car_collision;

  localparam int LIVES_N = 3;
  localparam int CD_N    = 60;

  logic       CLK = 1'b0;
  logic       RST;
  logic       frame_tick;
  logic [9:0] frog_x, frog_y;
  logic [9:0] car_x1, car_x2, car_x3, car_x4, car_x5, car_x6;
  logic       hit;
  logic [1:0] lives;
  logic       game_over;
  logic       busy;
`ifdef COLLISION_LANE_ID_EN
  logic [2:0] hit_lane;
`endif

  car_collision dut (
    .CLK        (CLK),
    .RST        (RST),
    .frame_tick (frame_tick),
    .frog_x     (frog_x),
    .frog_y     (frog_y),
    .car_x1     (car_x1),
    .car_x2     (car_x2),
    .car_x3     (car_x3),
    .car_x4     (car_x4),
    .car_x5     (car_x5),
    .car_x6     (car_x6),
    .hit        (hit),
    .lives      (lives),
    .game_over  (game_over),
    .busy       (busy)
`ifdef COLLISION_LANE_ID_EN
    ,
    .hit_lane   (hit_lane)
`endif
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  int m_lives;
  int m_cd;
  int m_hl;
  bit m_over;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // First lane 0..5 whose car overlaps the frog, or -1
  function automatic int ref_lane(input int fx, input int fy,
                                  input int c[6]);
    for (int k = 0; k < 6; k++) begin
      int top = 64 + 32 * k;
      bit v = (fy >= top) && (fy < top + 32);
      bit h = (((fx - c[k]) % 1024 + 1024) % 1024 < 32) ||
              (((c[k] - fx) % 1024 + 1024) % 1024 < 32);
      if (v && h) return k;
    end
    return -1;
  endfunction

  task automatic drive(input int fx, input int fy, input int c[6]);
    frog_x = 10'(fx);
    frog_y = 10'(fy);
    car_x1 = 10'(c[0]);
    car_x2 = 10'(c[1]);
    car_x3 = 10'(c[2]);
    car_x4 = 10'(c[3]);
    car_x5 = 10'(c[4]);
    car_x6 = 10'(c[5]);
  endtask

  task automatic scramble();
    int c[6];
    foreach (c[i]) c[i] = int'($urandom_range(0, 1023));
    drive(int'($urandom_range(0, 1023)),
          int'($urandom_range(0, 1023)), c);
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_lives"}, 32'(lives), 32'(m_lives));
    chk({tag, "_over"}, 32'(game_over), 32'(m_over));
    chk({tag, "_busy"}, 32'(busy), 32'(!m_over && m_cd > 0));
`ifdef COLLISION_LANE_ID_EN
    chk({tag, "_lane"}, 32'(hit_lane), 32'(m_hl));
`endif
  endtask

  task automatic do_reset();
    frame_tick = 1'b0;
    RST = 1'b1;
    m_lives = LIVES_N;
    m_cd    = 0;
    m_hl    = 7;
    m_over  = 1'b0;
    @(posedge CLK); #1;
    chk("rst_hit", 32'(hit), 32'd0);
    check_outputs("rst");
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  // One frame: tick, optional ignored tick during scan, check result
  task automatic frame(input string tag, input int fx, input int fy,
                       input int c[6], input bit spur);
    int  k;
    int  hits;
    int  first;
    bit  scan;
    @(posedge CLK); #1;
    drive(fx, fy, c);
    frame_tick = 1'b1;
    scan = !m_over && m_cd == 0;
    k = -1;
    if (!m_over && m_cd > 0) m_cd--;
    if (scan) begin
      k = ref_lane(fx, fy, c);
      if (k >= 0) begin
        m_lives--;
        m_hl = k;
        if (m_lives == 0) m_over = 1'b1;
        else              m_cd = CD_N;
      end
    end
    hits  = 0;
    first = -1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge CLK); #1;
      if (i == 1) begin
        frame_tick = spur && scan;
        scramble();
        chk({tag, "_busy1"}, 32'(busy),
            32'(scan ? 1'b1 : (!m_over && m_cd > 0)));
      end else begin
        frame_tick = 1'b0;
      end
      if (scan && k < 0 && i == 6) chk({tag, "_busy6"}, 32'(busy), 32'd1);
      if (scan && k < 0 && i == 7) chk({tag, "_busy7"}, 32'(busy), 32'd0);
      if (hit === 1'b1) begin
        hits++;
        if (first < 0) first = i;
      end
    end
    chk({tag, "_nhit"}, 32'(hits), 32'(k >= 0 ? 1 : 0));
    chk({tag, "_hitat"}, 32'(first), 32'(k >= 0 ? k + 2 : -1));
    check_outputs(tag);
  endtask

  int cz[6];
  int cl[6];

  initial begin
    frame_tick = 1'b0;
    RST = 1'b1;
    cz = '{500, 500, 500, 500, 500, 500};
    drive(0, 0, cz);
    #1;
    chk("async_rst_hit", 32'(hit), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    do_reset();

    // No overlap: frog above all lanes
    foreach (cl[i]) cl[i] = int'($urandom_range(0, 1023));
    frame("noov", 100, 0, cl, 1'b0);

    // Lane 2 hit, then cooldown and game over
    cl = '{700, 700, 90, 700, 700, 700};
    frame("lane2", 100, 128, cl, 1'b0);
    for (int f = 0; f < 60; f++) frame("cool", 100, 128, cl, 1'b0);
    frame("hit2", 100, 128, cl, 1'b0);
    for (int f = 0; f < 60; f++) frame("cool2", 100, 128, cl, 1'b0);
    frame("hit3", 100, 128, cl, 1'b0);
    for (int f = 0; f < 3; f++) frame("over", 100, 128, cl, 1'b0);

    // Wrap-around overlap and its near miss
    do_reset();
    cl = '{1010, 500, 500, 500, 500, 500};
    frame("wrap", 5, 64, cl, 1'b0);
    do_reset();
    cl = '{900, 500, 500, 500, 500, 500};
    frame("nowrap", 5, 64, cl, 1'b0);

    // Asynchronous reset while lane 2 is being evaluated
    do_reset();
    cl = '{700, 700, 90, 700, 700, 700};
    @(posedge CLK); #1;
    drive(100, 128, cl);
    frame_tick = 1'b1;
    @(posedge CLK); #1;
    frame_tick = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    #1 RST = 1'b1;
    #1;
    chk("abort_hit", 32'(hit), 32'd0);
    check_outputs("abort");
    @(posedge CLK); #1;
    RST = 1'b0;
    begin
      int seen = 0;
      for (int i = 0; i < 10; i++) begin
        @(posedge CLK); #1;
        if (hit === 1'b1) seen++;
      end
      chk("abort_nohit", 32'(seen), 32'd0);
    end
    check_outputs("abort_after");
    frame("lane2b", 100, 128, cl, 1'b0);

    // Randomised frames with ignored mid-scan ticks
    do_reset();
    for (int f = 0; f < 400; f++) begin
      int fx = int'($urandom_range(0, 1023));
      int fy = int'($urandom_range(0, 300));
      foreach (cl[i]) begin
        if ($urandom_range(0, 2) == 0)
          cl[i] = (fx + int'($urandom_range(0, 80)) - 40 + 1024) % 1024;
        else
          cl[i] = int'($urandom_range(0, 1023));
      end
      if (m_cd > 3 && $urandom_range(0, 1) == 0) m_cd = m_cd;
      frame("rnd", fx, fy, cl, 1'($urandom_range(0, 1)));
      if (m_over && $urandom_range(0, 3) == 0) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
